// File: rtl/scrubbed_data_memory.sv
// Single-port byte-enable data memory with a registered read path, access-error
// detection and a clear sequencer that zeroes every word after reset.
module scrubbed_data_memory #(
   parameter int address_width = 6,
   parameter int word_width    = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    request_valid,
   output logic                    request_ready,
   input  logic                    write_enable,
   input  logic [word_width/8-1:0] byte_enable,
   input  logic [31:0]             address,
   input  logic [word_width-1:0]   write_data,
   output logic [word_width-1:0]   read_data,
   output logic                    read_valid,
   output logic                    access_error,
   output logic                    clear_busy
);

   localparam int          offset_bits = $clog2(word_width / 8);
   localparam int          bytes       = word_width / 8;
   localparam int          depth       = 2 ** address_width;
   localparam int          top_bit     = offset_bits + address_width;
   localparam logic [31:0] offset_mask = 32'((1 << offset_bits) - 1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                   state_q, state_d;
   logic [address_width-1:0] clear_index_q, clear_index_d;
   logic                     request_ready_q, request_ready_d;
   logic                     clear_busy_q, clear_busy_d;
   logic                     read_valid_q, read_valid_d;
   logic                     access_error_q, access_error_d;
   logic [word_width-1:0]    read_data_q, read_data_d;

   logic [word_width-1:0]    mem [depth];
   logic [bytes-1:0]         mem_byte_we;
   logic [address_width-1:0] mem_addr;
   logic [word_width-1:0]    mem_wdata;

   logic [address_width-1:0] word_index;
   logic                     addr_error;
   logic                     accept;

   assign word_index = address[offset_bits +: address_width];
   // Misaligned when any byte-offset bit is set; out of range when any bit above the array is set.
   assign addr_error = ((address & offset_mask) != 32'd0) || ((address >> top_bit) != 32'd0);
   assign accept     = request_valid && request_ready_q;

   always_comb begin
      state_d        = state_q;
      clear_index_d  = clear_index_q;
      read_data_d    = read_data_q;
      read_valid_d   = 1'b0;
      access_error_d = 1'b0;
      mem_byte_we    = '0;
      mem_addr       = word_index;
      mem_wdata      = write_data;

      case (state_q)
         CLEAR: begin
            mem_byte_we   = '1;
            mem_addr      = clear_index_q;
            mem_wdata     = '0;
            clear_index_d = clear_index_q + address_width'(1);
            if (clear_index_q == '1) state_d = IDLE;
         end
         default: begin
            if (accept) begin
               if (addr_error) begin
                  access_error_d = 1'b1;
               end else if (write_enable) begin
                  mem_byte_we = byte_enable;
               end else begin
                  read_data_d  = mem[word_index];
                  read_valid_d = 1'b1;
               end
            end
         end
      endcase

      // A reset cycle must not disturb the array; the restarted clear rewrites it anyway.
      if (!reset_n) mem_byte_we = '0;

      request_ready_d = (state_d == IDLE);
      clear_busy_d    = (state_d == CLEAR);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q         <= CLEAR;
         clear_index_q   <= '0;
         request_ready_q <= 1'b0;
         clear_busy_q    <= 1'b1;
         read_valid_q    <= 1'b0;
         access_error_q  <= 1'b0;
         read_data_q     <= '0;
      end else begin
         state_q         <= state_d;
         clear_index_q   <= clear_index_d;
         request_ready_q <= request_ready_d;
         clear_busy_q    <= clear_busy_d;
         read_valid_q    <= read_valid_d;
         access_error_q  <= access_error_d;
         read_data_q     <= read_data_d;
      end
   end

   // NOTE: the array has no reset term so it maps onto RAM; the clear sequencer zeroes it instead.
   always_ff @(posedge clock) begin
      for (int k = 0; k < bytes; k++) begin
         if (mem_byte_we[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
   end

   assign request_ready = request_ready_q;
   assign clear_busy    = clear_busy_q;
   assign read_valid    = read_valid_q;
   assign access_error  = access_error_q;
   assign read_data     = read_data_q;

endmodule

// File: tb/tb_scrubbed_data_memory.sv
// Randomised bench for scrubbed_data_memory: a default 32-bit instance against a
// word-array reference model, plus a 64-bit / 16-word instance for the parameter sweep.
module tb_scrubbed_data_memory;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // default instance (32-bit words, 64 words)
   logic        reset_n_a, valid_a, ready_a, we_a, rv_a, err_a, busy_a;
   logic [3:0]  be_a;
   logic [31:0] addr_a, wd_a, rd_a;

   // sweep instance (64-bit words, 16 words)
   logic        reset_n_b, valid_b, ready_b, we_b, rv_b, err_b, busy_b;
   logic [7:0]  be_b;
   logic [31:0] addr_b;
   logic [63:0] wd_b, rd_b;

   scrubbed_data_memory dut_a (
      .clock(clock), .reset_n(reset_n_a), .request_valid(valid_a), .request_ready(ready_a),
      .write_enable(we_a), .byte_enable(be_a), .address(addr_a), .write_data(wd_a),
      .read_data(rd_a), .read_valid(rv_a), .access_error(err_a), .clear_busy(busy_a)
   );

   scrubbed_data_memory #(.address_width(4), .word_width(64)) dut_b (
      .clock(clock), .reset_n(reset_n_b), .request_valid(valid_b), .request_ready(ready_b),
      .write_enable(we_b), .byte_enable(be_b), .address(addr_b), .write_data(wd_b),
      .read_data(rd_b), .read_valid(rv_b), .access_error(err_b), .clear_busy(busy_b)
   );

   // reference model for the default instance: plain word array plus last read result
   logic [31:0] model_a [64];
   logic [31:0] last_rd_a;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic reset_clear_a(input int hold);
      int n;
      int ready_in_clear;
      reset_n_a = 1'b0;
      valid_a   = 1'b0;
      repeat (hold) @(posedge clock);
      #1;
      check("reset_busy_a", busy_a, 1);
      check("reset_ready_a", ready_a, 0);
      check("reset_rv_a", rv_a, 0);
      check("reset_err_a", err_a, 0);
      check("reset_rdata_a", rd_a, 0);
      reset_n_a      = 1'b1;
      n              = 0;
      ready_in_clear = 0;
      while (busy_a === 1'b1 && n < 200) begin
         n++;
         if (ready_a !== 1'b0) ready_in_clear++;
         @(posedge clock);
         #1;
      end
      check("clear_cycles_a", n, 64);
      check("ready_during_clear_a", ready_in_clear, 0);
      check("ready_after_clear_a", ready_a, 1);
      for (int i = 0; i < 64; i++) model_a[i] = '0;
      last_rd_a = '0;
   endtask

   task automatic do_a(input logic v, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
      logic exp_rv, exp_err;
      int   idx;
      check("ready_a", ready_a, 1);
      valid_a = v;
      we_a    = we;
      be_a    = be;
      addr_a  = addr;
      wd_a    = wd;
      exp_rv  = 1'b0;
      exp_err = 1'b0;
      if (v) begin
         if ((addr % 4) != 0 || addr >= 256) begin
            exp_err = 1'b1;
         end else begin
            idx = int'(addr / 4);
            if (we) begin
               for (int k = 0; k < 4; k++) begin
                  if (be[k]) model_a[idx][8*k +: 8] = wd[8*k +: 8];
               end
            end else begin
               last_rd_a = model_a[idx];
               exp_rv    = 1'b1;
            end
         end
      end
      @(posedge clock);
      #1;
      valid_a = 1'b0;
      check("read_valid_a", rv_a, exp_rv);
      check("access_error_a", err_a, exp_err);
      check("read_data_a", rd_a, last_rd_a);
   endtask

   task automatic idle_a();
      valid_a = 1'b0;
      @(posedge clock);
      #1;
      check("idle_rv_a", rv_a, 0);
      check("idle_err_a", err_a, 0);
      check("idle_rdata_a", rd_a, last_rd_a);
   endtask

   task automatic do_b(input logic we, input logic [7:0] be, input logic [31:0] addr,
                       input logic [63:0] wd);
      valid_b = 1'b1;
      we_b    = we;
      be_b    = be;
      addr_b  = addr;
      wd_b    = wd;
      @(posedge clock);
      #1;
      valid_b = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] addr;
      int r;

      reset_n_a = 1'b0; valid_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; wd_a = '0;
      reset_n_b = 1'b0; valid_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; wd_b = '0;

      // clear timing and zeroed contents
      reset_clear_a(2);
      do_a(1, 0, 4'h0, 32'h00, 32'h0);
      do_a(1, 0, 4'h0, 32'hFC, 32'h0);
      check("read_fc_zero", rd_a, 32'h0);

      // byte-enable merge
      do_a(1, 1, 4'b1111, 32'h10, 32'hAABBCCDD);
      do_a(1, 1, 4'b0101, 32'h10, 32'h11223344);
      do_a(1, 0, 4'h0, 32'h10, 32'h0);
      check("merge_value", rd_a, 32'hAA22CC44);
      do_a(1, 1, 4'b0000, 32'h10, 32'h55555555);
      do_a(1, 0, 4'h0, 32'h10, 32'h0);

      // misaligned and out-of-range requests
      do_a(1, 0, 4'h0, 32'h13, 32'h0);
      idle_a();
      do_a(1, 1, 4'hF, 32'h100, 32'hFFFFFFFF);
      idle_a();
      do_a(1, 0, 4'h0, 32'h00, 32'h0);
      do_a(1, 0, 4'h0, 32'h8000_0000, 32'h0);

      // streaming reads on consecutive cycles
      do_a(1, 1, 4'hF, 32'h00, 32'h0000_1111);
      do_a(1, 1, 4'hF, 32'h04, 32'h0000_2222);
      do_a(1, 1, 4'hF, 32'h08, 32'h0000_3333);
      do_a(1, 0, 4'h0, 32'h00, 32'h0);
      do_a(1, 0, 4'h0, 32'h04, 32'h0);
      do_a(1, 0, 4'h0, 32'h08, 32'h0);
      idle_a();

      // reset in IDLE, then again in the middle of the clear
      do_a(1, 1, 4'hF, 32'h20, 32'hDEADBEEF);
      reset_n_a = 1'b0;
      @(posedge clock);
      #1;
      reset_n_a = 1'b1;
      repeat (30) @(posedge clock);
      #1;
      check("busy_mid_clear", busy_a, 1);
      reset_clear_a(1);
      do_a(1, 0, 4'h0, 32'h20, 32'h0);
      check("word_zero_after_reset", rd_a, 32'h0);

      // randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)       addr = 32'($urandom_range(0, 63)) * 32'd4;
         else if (r == 7) addr = 32'($urandom_range(0, 255));
         else if (r == 8) addr = 32'($urandom_range(256, 1023));
         else             addr = $urandom;
         if ($urandom_range(0, 5) == 0) idle_a();
         else do_a(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), addr, $urandom);
      end

      // parameter sweep instance: 64-bit words, 16-word array
      repeat (2) @(posedge clock);
      #1;
      check("reset_busy_b", busy_b, 1);
      check("reset_ready_b", ready_b, 0);
      reset_n_b = 1'b1;
      n = 0;
      while (busy_b === 1'b1 && n < 200) begin
         n++;
         @(posedge clock);
         #1;
      end
      check("clear_cycles_b", n, 16);
      check("ready_after_clear_b", ready_b, 1);
      do_b(0, 8'h00, 32'h04, 64'h0);
      check("misaligned_err_b", err_b, 1);
      check("misaligned_rv_b", rv_b, 0);
      do_b(1, 8'hFF, 32'h08, 64'h0123_4567_89AB_CDEF);
      check("write_err_b", err_b, 0);
      do_b(1, 8'h80, 32'h08, 64'hFFFF_FFFF_FFFF_FFFF);
      do_b(0, 8'h00, 32'h08, 64'h0);
      check("top_byte_rv_b", rv_b, 1);
      check("top_byte_data_b", rd_b, 64'hFF23_4567_89AB_CDEF);
      do_b(0, 8'h00, 32'h80, 64'h0);
      check("range_err_b", err_b, 1);
      do_b(0, 8'h00, 32'h78, 64'h0);
      check("last_word_zero_b", rd_b, 64'h0);
      check("last_word_rv_b", rv_b, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
